// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer for the 6-bit accumulator CPU
//
// Optional single-step mode: define SEQ_SINGLE_STEP_EN to add the step input.
// With it, a non-HALT instruction parks in DECODE until step is high.
// Without it, DECODE always lasts one cycle.

module cpu_sequencer #(
  parameter int         PC_W     = 8,
  parameter int         PROG_LEN = 256,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            start,
  input  logic            abort,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [5:0]      imem_data,
  output logic [5:0]      instr_out,
  output logic            exec_en,
  output logic [PC_W-1:0] pc_out,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_DONE
  } state_t;

  // Address of the last instruction; the terminal check fires here, so the
  // PC never increments past it even when PROG_LEN equals 2^PC_W.
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [5:0]      r_instr;
  logic            r_req;
  logic            r_exec;
  logic            r_busy;
  logic            r_halted;

  logic            w_is_halt;
  logic            w_at_last;
  logic            w_step_go;

  assign w_is_halt = (r_instr[5:2] == HALT_OP);
  assign w_at_last = (r_pc == LAST_PC);

`ifdef SEQ_SINGLE_STEP_EN
  assign w_step_go = step;
`else
  assign w_step_go = 1'b1;
`endif

  // Sequencer FSM; every output is registered alongside the state so that
  // reset clears imem_req and exec_en immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_instr  <= 6'b0;
      r_req    <= 1'b0;
      r_exec   <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else if (abort) begin
      // abort outranks start, imem_valid and step; instr_out keeps its value
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_req    <= 1'b0;
      r_exec   <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          // imem_req is high for the whole FETCH state, so valid is only
          // ever accepted here; address stays at the PC while waiting.
          if (imem_valid) begin
            r_state <= S_DECODE;
            r_instr <= imem_data;
            r_req   <= 1'b0;
          end
        end

        S_DECODE: begin
          // HALT never reaches EXECUTE and never waits for step
          if (w_is_halt) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (w_step_go) begin
            r_state <= S_EXECUTE;
            r_exec  <= 1'b1;
          end
        end

        S_EXECUTE: begin
          r_exec <= 1'b0;
          if (w_at_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_pc    <= r_pc + PC_W'(1);
            r_req   <= 1'b1;
          end
        end

        S_DONE: begin
          if (start) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_req    <= 1'b1;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_pc     <= '0;
          r_req    <= 1'b0;
          r_exec   <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign instr_out = r_instr;
  assign exec_en   = r_exec;
  assign pc_out    = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/decode/execute controller for the 6-bit accumulator CPU.
- Owns the program counter and fetches one 6-bit instruction at a time from instruction memory over a req/valid handshake.
- Presents the fetched instruction to instruction_decoder, then opens a one-cycle execute window that gates the decoder's ALU/RF/accumulator enables.
- Sits between program memory and the decoder/ALU/register-file datapath.

Parameters:
- PC_W, 8, program counter / instruction address width.
- PROG_LEN, 256, number of instructions. Execution stops after address PROG_LEN-1. Legal range 1..2^PC_W.
- HALT_OP, 4'hF, value of instruction[5:2] that the sequencer treats as HALT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins execution at PC=0
- abort  input  1  synchronous; returns to IDLE from any state
- imem_req  output  1  fetch request; held until accepted
- imem_addr  output  PC_W  fetch address; equals PC while imem_req=1
- imem_valid  input  1  memory data valid; accepted only while imem_req=1
- imem_data  input  6  fetched instruction
- instr_out  output  6  registered instruction to instruction_decoder
- exec_en  output  1  execute strobe; ANDed with decoder ALU_ce/RF_ce/A_ce
- pc_out  output  PC_W  current PC
- busy  output  1  high in FETCH, DECODE, EXECUTE
- halted  output  1  high in DONE
- step  input  1  present only with SEQ_SINGLE_STEP_EN

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, PC=0, instr_out=6'b0, imem_req=0, exec_en=0, busy=0, halted=0.
  - A reset during a fetch drops imem_req at once; an imem_valid arriving later is ignored.
- States: IDLE, FETCH, DECODE, EXECUTE, DONE.
- IDLE:
  - start=1 -> PC=0, next state FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - When imem_valid=1, register imem_data into instr_out, next state DECODE. Zero-wait memory, where valid arrives in the same cycle as req, is legal.
  - If imem_valid=0, stay in FETCH with address stable, for unbounded cycles.
- DECODE:
  - exec_en=0 for one cycle so the decoder outputs settle.
  - If instr_out[5:2]==HALT_OP -> DONE.
  - Otherwise -> EXECUTE.
- EXECUTE:
  - exec_en=1 for exactly one cycle.
  - If PC==PROG_LEN-1 -> DONE, and PC holds.
  - Otherwise PC=PC+1 and next state FETCH.
- DONE:
  - halted=1; PC and instr_out hold.
  - start=1 -> PC=0, next state FETCH (restart).
- Throughput: minimum 3 cycles per instruction (FETCH, DECODE, EXECUTE) with zero-wait memory.
- Start latency: start sampled at edge N gives imem_req=1 during cycle N+1.
- PC arithmetic:
  - PC_W-bit unsigned.
  - With PROG_LEN=2^PC_W, the terminal check fires before any wrap, so PC never overflows.
- The HALT instruction itself never produces exec_en; the PC stays at the HALT address.
- Simultaneous events:
  - abort has priority over start, imem_valid and step; abort goes to IDLE with PC=0 and exec_en=0.
  - start while busy=1 is ignored.
  - imem_valid outside FETCH is ignored.
- NOP and all other opcodes are sequenced identically. Decoding them is instruction_decoder's job.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Input step exists.
  - From DECODE with a non-HALT opcode, the FSM waits in DECODE until step=1, then goes to EXECUTE.
  - Each step pulse executes exactly one instruction.
  - A HALT opcode goes to DONE without waiting for step.
- Undefined:
  - No step port.
  - DECODE always lasts exactly one cycle.

Test Plan:
- Reset mid-FETCH (imem_req=1, PC=5), assert rst -> imem_req=0 in the same cycle; PC=0, instr_out=0, IDLE. A late imem_valid causes no state change.
- PROG_LEN=4, zero-wait memory holding {6'h08, 6'h05, 6'h02, 6'h07}, pulse start -> exec_en high on cycles 3, 6, 9, 12 after start. instr_out matches each word in its execute cycle. halted=1 after the 4th execute; PC=3.
- Memory holds 6'h3C (HALT_OP=F) at address 2 -> two execute strobes only; halted=1 with pc_out=2 and instr_out=6'h3C.
- imem_valid delayed 4 cycles at address 1 -> imem_req and imem_addr=1 stable for 5 cycles, exec_en stays 0 until DECODE completes.
- abort and start asserted together during EXECUTE -> exec_en drops next cycle; IDLE with PC=0. start the following cycle restarts the fetch at address 0.
- With SEQ_SINGLE_STEP_EN, step held 0 -> FSM parks in DECODE with exec_en=0. A single step pulse -> exactly one exec_en cycle and PC advances by 1.
